// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipe_pkg;

  // Widest register index held in a shadow (NREG up to 32)
  localparam int REG_W_MAX = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] rd;
    logic                 regwrite;
    logic                 load;
    logic                 memacc;
  } stage_shadow_t;

  // Register index width for a given architectural register count
  function automatic int reg_w(input int nreg);
    return (nreg > 2) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - execute-stage forwarding selector for one source operand
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic [REG_W-1:0] i_src,
  input  logic             i_m_valid,
  input  logic             i_m_regwrite,
  input  logic             i_m_load,
  input  logic [REG_W-1:0] i_m_rd,
  input  logic             i_w_valid,
  input  logic             i_w_regwrite,
  input  logic [REG_W-1:0] i_w_rd,
  output fwd_sel_t         o_sel
);

  logic w_m_hit;
  logic w_w_hit;

  // With a registered data memory a load result is not yet available in M
  assign w_m_hit = i_m_valid && i_m_regwrite && (i_m_rd != '0) && (i_m_rd == i_src)
                   && !((LOAD_LAT == 2) && i_m_load);
  assign w_w_hit = i_w_valid && i_w_regwrite && (i_w_rd != '0) && (i_w_rd == i_src);

  // Youngest producer (M) wins over W; x0 never forwards
  always_comb begin
    o_sel = FWD_RF;
    if (w_m_hit) begin
      o_sel = FWD_MEM;
    end else if (w_w_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forward control for the 5-stage core; HAZARD_PERF_EN adds event counters
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int LOAD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [reg_w(NREG)-1:0] Rs1_D,
  input  logic [reg_w(NREG)-1:0] Rs2_D,
  input  logic [reg_w(NREG)-1:0] Rd_D,
  input  logic                   RegWrite_D,
  input  logic                   Load_D,
  input  logic                   MemAcc_D,
  input  logic                   ImemValid_F,
  input  logic                   PCSrc_E,
  input  logic                   DmemReady_M,
  output logic                   Stall_F,
  output logic                   Stall_D,
  output logic                   Flush_D,
  output logic                   Stall_E,
  output logic                   Flush_E,
  output logic                   Stall_M,
  output logic [1:0]             ForwardA_E,
  output logic [1:0]             ForwardB_E,
  output logic                   Valid_E,
  output logic                   Valid_M,
  output logic                   Valid_W
`ifdef HAZARD_PERF_EN
  ,
  output logic [63:0]            StallCnt,
  output logic [63:0]            FlushCnt
`endif
);

  localparam int REG_W = reg_w(NREG);

  logic             r_v_d;
  stage_shadow_t    r_e;
  stage_shadow_t    r_m;
  stage_shadow_t    r_w;
  logic [REG_W-1:0] r_rs1_e;
  logic [REG_W-1:0] r_rs2_e;

  stage_shadow_t    w_d_shadow;
  logic [REG_W-1:0] w_rd_e;
  logic [REG_W-1:0] w_rd_m;
  logic [REG_W-1:0] w_rd_w;
  logic             w_hit_e;
  logic             w_hit_m;
  logic             w_lu_raw;
  logic             w_mem_wait;
  logic             w_redirect;
  logic             w_load_use;
  logic             w_fetch_wait;
  fwd_sel_t         w_fwd_a;
  fwd_sel_t         w_fwd_b;
  logic             w_unused;

  assign w_d_shadow = '{valid:    r_v_d,
                        rd:       REG_W_MAX'(Rd_D),
                        regwrite: RegWrite_D,
                        load:     Load_D,
                        memacc:   MemAcc_D};

  assign w_rd_e = r_e.rd[REG_W-1:0];
  assign w_rd_m = r_m.rd[REG_W-1:0];
  assign w_rd_w = r_w.rd[REG_W-1:0];

  // A producer in E or M hits the decode instruction when it writes a source it reads
  assign w_hit_e  = (w_rd_e != '0) && ((w_rd_e == Rs1_D) || (w_rd_e == Rs2_D));
  assign w_hit_m  = (w_rd_m != '0) && ((w_rd_m == Rs1_D) || (w_rd_m == Rs2_D));
  assign w_lu_raw = (r_e.valid && r_e.load && w_hit_e)
                    || ((LOAD_LAT == 2) && r_m.valid && r_m.load && w_hit_m);

  // Resolve hazard events in priority order: mem_wait, redirect, load_use, fetch_wait
  always_comb begin
    w_mem_wait   = r_m.valid && r_m.memacc && !DmemReady_M;
    w_redirect   = r_e.valid && PCSrc_E && !w_mem_wait;
    w_load_use   = w_lu_raw && !w_mem_wait && !w_redirect;
    w_fetch_wait = !ImemValid_F && !w_mem_wait && !w_redirect && !w_load_use;
  end

  assign Stall_F = w_mem_wait || w_load_use || w_fetch_wait;
  assign Stall_D = w_mem_wait || w_load_use;
  assign Stall_E = w_mem_wait;
  assign Stall_M = w_mem_wait;
  assign Flush_D = w_redirect || w_fetch_wait;
  assign Flush_E = w_redirect || w_load_use;

  assign Valid_E = r_e.valid;
  assign Valid_M = r_m.valid;
  assign Valid_W = r_w.valid;

  // W shadow keeps the full record for debug visibility; only rd/regwrite matter here
  assign w_unused = ^{r_w.load, r_w.memacc};

  // Advance, freeze or bubble the per-stage valid bits and register-usage shadows
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_d   <= 1'b0;
      r_e     <= '0;
      r_m     <= '0;
      r_w     <= '0;
      r_rs1_e <= '0;
      r_rs2_e <= '0;
    end else if (w_mem_wait) begin
      r_w <= '0;
    end else begin
      r_w <= r_m;
      r_m <= r_e;
      if (w_redirect || w_load_use) begin
        r_e     <= '0;
        r_rs1_e <= '0;
        r_rs2_e <= '0;
      end else begin
        r_e     <= w_d_shadow;
        r_rs1_e <= Rs1_D;
        r_rs2_e <= Rs2_D;
      end
      if (w_redirect || w_fetch_wait) begin
        r_v_d <= 1'b0;
      end else if (!w_load_use) begin
        r_v_d <= 1'b1;
      end
    end
  end

  fwd_sel #(.REG_W(REG_W), .LOAD_LAT(LOAD_LAT)) u_fwd_a (
    .i_src        (r_rs1_e),
    .i_m_valid    (r_m.valid),
    .i_m_regwrite (r_m.regwrite),
    .i_m_load     (r_m.load),
    .i_m_rd       (w_rd_m),
    .i_w_valid    (r_w.valid),
    .i_w_regwrite (r_w.regwrite),
    .i_w_rd       (w_rd_w),
    .o_sel        (w_fwd_a)
  );

  fwd_sel #(.REG_W(REG_W), .LOAD_LAT(LOAD_LAT)) u_fwd_b (
    .i_src        (r_rs2_e),
    .i_m_valid    (r_m.valid),
    .i_m_regwrite (r_m.regwrite),
    .i_m_load     (r_m.load),
    .i_m_rd       (w_rd_m),
    .i_w_valid    (r_w.valid),
    .i_w_regwrite (r_w.regwrite),
    .i_w_rd       (w_rd_w),
    .o_sel        (w_fwd_b)
  );

  assign ForwardA_E = w_fwd_a;
  assign ForwardB_E = w_fwd_b;

`ifdef HAZARD_PERF_EN
  logic [63:0] r_stall_cnt;
  logic [63:0] r_flush_cnt;

  // Count stall cycles and redirect events; both wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_load_use || w_mem_wait) begin
        r_stall_cnt <= r_stall_cnt + 64'd1;
      end
      if (w_redirect) begin
        r_flush_cnt <= r_flush_cnt + 64'd1;
      end
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int NCYC = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rd_D;
  logic       RegWrite_D, Load_D, MemAcc_D, ImemValid_F, PCSrc_E, DmemReady_M;
  logic       Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Stall_M;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       Valid_E, Valid_M, Valid_W;
`ifdef HAZARD_PERF_EN
  logic [63:0] StallCnt, FlushCnt;
`endif

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
    .RegWrite_D(RegWrite_D), .Load_D(Load_D), .MemAcc_D(MemAcc_D),
    .ImemValid_F(ImemValid_F), .PCSrc_E(PCSrc_E), .DmemReady_M(DmemReady_M),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D),
    .Stall_E(Stall_E), .Flush_E(Flush_E), .Stall_M(Stall_M),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .Valid_E(Valid_E), .Valid_M(Valid_M), .Valid_W(Valid_W)
`ifdef HAZARD_PERF_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  // One in-flight instruction as seen by the model
  typedef struct {
    int         tag;
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       rw, ld, ma, br;
    int         mwait;
    int         gap;
  } slot_t;

  slot_t prog[20];
  int    np;
  slot_t sD, sE, sM, sW, empty_s;
  int    n_pass, n_total;
  int    fi, gap_left, mcnt;
  longint unsigned m_stall_cnt, m_flush_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add_ins(input int rs1, input int rs2, input int rd, input logic rw,
                         input logic ld, input logic ma, input logic br,
                         input int mwait, input int gap);
    prog[np].tag   = np;
    prog[np].v     = 1'b1;
    prog[np].rs1   = 5'(rs1);
    prog[np].rs2   = 5'(rs2);
    prog[np].rd    = 5'(rd);
    prog[np].rw    = rw;
    prog[np].ld    = ld;
    prog[np].ma    = ma;
    prog[np].br    = br;
    prog[np].mwait = mwait;
    prog[np].gap   = gap;
    np++;
  endtask

  // Producer in M beats producer in W; x0 is never forwarded
  function automatic logic [1:0] exp_fwd(input logic [4:0] s);
    if (sM.v && sM.rw && sM.rd != 5'd0 && sM.rd == s) return 2'b10;
    if (sW.v && sW.rw && sW.rd != 5'd0 && sW.rd == s) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    logic mw, rdv, lu, fw, imem, ready, after_rst, rst_done;
    int   m10, o_sf, o_sd, o_fd, o_fe, o_sm;

    np = 0; n_pass = 0; n_total = 0;
    //      rs1 rs2 rd rw    ld    ma    br   mw gap
    add_ins(1,  0,  5, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0); // 0  ld  x5,0(x1)
    add_ins(5,  2,  6, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); // 1  add x6,x5,x2
    add_ins(0,  0,  3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); // 2  addi x3,x0,7
    add_ins(3,  3,  4, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); // 3  add x4,x3,x3
    add_ins(3,  4,  5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); // 4  sub x5,x3,x4
    add_ins(0,  0,  0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1); // 5  addi x0,x0,1 (one empty fetch first)
    add_ins(0,  0,  7, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); // 6  add x7,x0,x0
    add_ins(2,  0,  8, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0); // 7  load that also redirects
    add_ins(8,  8,  9, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); // 8  add x9,x8,x8 (squashed)
    add_ins(0,  0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0); // 9  nop
    add_ins(1,  2,  0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 0); // 10 sd x2,0(x1), 3 wait cycles
    add_ins(0,  0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0); // 11 taken beq
    add_ins(1,  1, 10, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); // 12 add x10 (squashed)
    add_ins(0,  0, 12, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); // 13 addi x12
    add_ins(12, 12, 13, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); // 14 add x13,x12,x12
    add_ins(13, 12, 14, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); // 15 add x14,x13,x12
    add_ins(14, 13, 15, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); // 16 add x15,x14,x13
    add_ins(15, 14, 16, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); // 17 add x16 (after reset)
    add_ins(16, 16, 17, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); // 18 add x17,x16,x16

    empty_s = '{default: 0};
    empty_s.tag = -1;
    sD = empty_s; sE = empty_s; sM = empty_s; sW = empty_s;
    fi = 0; gap_left = prog[0].gap; mcnt = 0;
    m_stall_cnt = 0; m_flush_cnt = 0;
    after_rst = 1'b0; rst_done = 1'b0;
    m10 = 0; o_sf = 0; o_sd = 0; o_fd = 0; o_fe = 0; o_sm = 0;

    rst = 1'b1; Rs1_D = '0; Rs2_D = '0; Rd_D = '0;
    RegWrite_D = 1'b0; Load_D = 1'b0; MemAcc_D = 1'b0;
    ImemValid_F = 1'b1; PCSrc_E = 1'b0; DmemReady_M = 1'b1;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      rst = (c < 2);
      if (!rst_done && sD.v && sE.v && sM.v && sW.v && sD.tag >= 16 && sD.tag < 100) begin
        rst = 1'b1;
        rst_done = 1'b1;
      end
      imem  = (gap_left == 0);
      ready = !(sM.v && sM.ma && mcnt > 0);
      Rs1_D = sD.rs1; Rs2_D = sD.rs2; Rd_D = sD.rd;
      RegWrite_D = sD.rw; Load_D = sD.ld; MemAcc_D = sD.ma;
      ImemValid_F = imem; PCSrc_E = sE.br; DmemReady_M = ready;
      #1;

      mw  = sM.v && sM.ma && !ready;
      rdv = sE.v && sE.br && !mw;
      lu  = !mw && !rdv && sE.v && sE.ld && sE.rd != 5'd0 && (sE.rd == sD.rs1 || sE.rd == sD.rs2);
      fw  = !mw && !rdv && !lu && !imem;

      if (c >= 1) begin
        chk("Stall_F", Stall_F, mw | lu | fw);
        chk("Stall_D", Stall_D, mw | lu);
        chk("Stall_E", Stall_E, mw);
        chk("Stall_M", Stall_M, mw);
        chk("Flush_D", Flush_D, rdv | fw);
        chk("Flush_E", Flush_E, rdv | lu);
        chk("ForwardA_E", ForwardA_E, exp_fwd(sE.rs1));
        chk("ForwardB_E", ForwardB_E, exp_fwd(sE.rs2));
        chk("Valid_E", Valid_E, sE.v);
        chk("Valid_M", Valid_M, sM.v);
        chk("Valid_W", Valid_W, sW.v);
`ifdef HAZARD_PERF_EN
        chk("StallCnt", StallCnt, m_stall_cnt);
        chk("FlushCnt", FlushCnt, m_flush_cnt);
`endif
        o_sf += int'(Stall_F); o_sd += int'(Stall_D); o_fd += int'(Flush_D);
        o_fe += int'(Flush_E); o_sm += int'(Stall_M);

        if (after_rst) begin
          chk("rst_valid", {Valid_E, Valid_M, Valid_W}, 3'b000);
          chk("rst_fwd", {ForwardA_E, ForwardB_E}, 4'b0000);
          chk("rst_stall_flush", {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E}, 6'b0);
`ifdef HAZARD_PERF_EN
          chk("rst_cnt", StallCnt | FlushCnt, 64'd0);
`endif
        end
        if (sE.tag == 1) chk("lu_fwd_add", {ForwardA_E, ForwardB_E}, 4'b0100);
        if (sM.tag == 0) chk("lu_bubble_E", Valid_E, 1'b0);
        if (sE.tag == 3) chk("alu_fwd_add", {ForwardA_E, ForwardB_E}, 4'b1010);
        if (sE.tag == 4) chk("alu_fwd_sub", {ForwardA_E, ForwardB_E}, 4'b0110);
        if (sE.tag == 6) chk("x0_fwd", {ForwardA_E, ForwardB_E, Stall_F}, 5'b00000);
        if (sE.tag == 7) chk("br_over_lu", {Flush_D, Flush_E, Stall_F, Stall_D}, 4'b1100);
        if (sM.tag == 7) chk("br_next_E", Valid_E, 1'b0);
        if (sM.tag == 10) begin
          m10++;
          if (m10 <= 3) chk("mw_stall", {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E}, 6'b111100);
          if (m10 >= 2) chk("mw_W_bubble", Valid_W, 1'b0);
          if (m10 == 4) chk("mw_release_br", {Stall_M, Flush_D, Flush_E}, 3'b011);
        end
      end

      if (rst) begin
        sD = empty_s; sE = empty_s; sM = empty_s; sW = empty_s;
        mcnt = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        after_rst = 1'b1;
      end else begin
        after_rst = 1'b0;
        if (lu || mw) m_stall_cnt++;
        if (rdv) m_flush_cnt++;
        if (mw) begin
          sW = empty_s;
          if (mcnt > 0) mcnt--;
        end else begin
          sW = sM;
          sM = sE;
          mcnt = sE.mwait;
          if (rdv || lu) sE = empty_s;
          else sE = sD;
          if (rdv || fw) begin
            sD = empty_s;
            if (fw && gap_left > 0) gap_left--;
          end else if (!lu) begin
            if (fi < np) begin
              sD = prog[fi];
              fi++;
              gap_left = (fi < np) ? prog[fi].gap : 0;
            end else begin
              sD = empty_s;
              sD.v = 1'b1;
              sD.tag = 100;
            end
          end
        end
      end
    end

    chk("total_Stall_F", 64'(o_sf), 64'd5);
    chk("total_Stall_D", 64'(o_sd), 64'd4);
    chk("total_Stall_M", 64'(o_sm), 64'd3);
    chk("total_Flush_D", 64'(o_fd), 64'd3);
    chk("total_Flush_E", 64'(o_fe), 64'd3);
    chk("seen_mem_wait", 64'(m10), 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline-control unit for the 5-stage RV64I/Zba core (F/D/E/M/W).
- Owns per-stage valid bits and a shadow copy of each in-flight instruction's register usage.
- From these it generates stall, flush and forwarding controls, adding hazard resolution, branch squash and memory-wait freezing that the current core top lacks.
- Instantiated once in the core top; its outputs drive the pipeline-register enables/clears and the execute-stage operand muxes.

Parameters:
- NREG, 32, architectural register count (32 = RV64I, 16 = RV64E); REG_W = $clog2(NREG).
- LOAD_LAT, 1, load-use bubbles required: 1 = data forwardable from M; 2 = registered data memory, forwardable from W only.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- Rs1_D  in  REG_W  decode source 1.
- Rs2_D  in  REG_W  decode source 2.
- Rd_D  in  REG_W  decode destination.
- RegWrite_D  in  1  decode writes Rd.
- Load_D  in  1  decode is a load (ResultSrc_D == 2'b01).
- MemAcc_D  in  1  decode is load or store.
- ImemValid_F  in  1  fetch word valid this cycle.
- PCSrc_E  in  1  execute redirect (taken branch/jump).
- DmemReady_M  in  1  data memory completes the M access this cycle.
- Stall_F  out  1  hold PC.
- Stall_D  out  1  hold F/D register.
- Flush_D  out  1  clear F/D register.
- Stall_E  out  1  hold D/E register.
- Flush_E  out  1  clear D/E register.
- Stall_M  out  1  hold E/M register.
- ForwardA_E  out  2  00 = RD1_E, 10 = ALUResult_M, 01 = Result_W.
- ForwardB_E  out  2  same encoding for RD2_E.
- Valid_E  out  1  execute-stage instruction is architectural.
- Valid_M  out  1  gates MemWrite_M.
- Valid_W  out  1  gates RegWrite_W.

Clock and reset:
- Single clock, clk; reset rst is synchronous and active-high.

Behaviour:
- State: valid bits V_D, V_E, V_M, V_W. Shadows: Rd, RegWrite, Load, MemAcc for E/M/W; Rs1, Rs2 for E.
- Reset: all valid bits 0, all shadows 0.
  - All stall/flush outputs are combinational and evaluate to 0 while V_* = 0 and the inputs are idle.
  - ForwardA_E = ForwardB_E = 00.
- Reset asserted mid-operation discards everything in flight on the next edge.
- Priority (highest first): mem_wait, redirect, load_use, fetch_wait.
- mem_wait = V_M & MemAcc_M & !DmemReady_M.
  - Asserts Stall_F, Stall_D, Stall_E, Stall_M; F..M shadows and valids hold.
  - V_W <= 0 (bubble into W).
  - Redirect and load-use are suppressed while mem_wait holds; they are re-evaluated when it releases, since E is frozen.
- redirect = V_E & PCSrc_E & !mem_wait.
  - Asserts Flush_D and Flush_E; next cycle V_D = 0, V_E = 0.
  - Overrides load_use.
- load_use = (V_E & Load_E & hit(Rd_E)) | (LOAD_LAT == 2 & V_M & Load_M & hit(Rd_M)).
  - hit(r) = r != 0 & (r == Rs1_D | r == Rs2_D).
  - Asserts Stall_F, Stall_D, Flush_E; V_E <= 0 and the D instruction is retained.
  - Duration: exactly LOAD_LAT cycles for a single dependence.
- fetch_wait = !ImemValid_F with no higher-priority event.
  - Asserts Flush_D; V_D <= 0 and the PC holds (Stall_F = 1).
- Normal advance: V_D <= 1, V_E <= V_D, V_M <= V_E, V_W <= V_M; shadows advance with them.
- Forwarding for source s in E:
  - 10 if V_M & RegWrite_M & Rd_M != 0 & Rd_M == s & !(LOAD_LAT == 2 & Load_M).
  - Else 01 if V_W & RegWrite_W & Rd_W != 0 & Rd_W == s.
  - Else 00.
  - M has priority over W for the same register.
- x0 is never forwarded and never causes a stall.
- All comparisons are REG_W wide; no wrap cases.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs StallCnt (64 bits; counts load_use | mem_wait cycles) and FlushCnt (64 bits; counts redirect events).
  - Both reset to 0 and wrap modulo 2^64.
  - A cycle with both load_use and mem_wait increments StallCnt by 1.
- Undefined: no counters and no extra ports; all other behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - the fwd_sel_t enum (FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10);
  - the stage_shadow_t struct (valid, rd, regwrite, load, memacc);
  - REG_W derivation helpers.
- One natural sub-module, fwd_sel: combinational per-operand forwarding selector, instantiated twice.

Test Plan:
- Load-use: `ld x5,0(x1)` then `add x6,x5,x2`, LOAD_LAT=1.
  - Expect one cycle of Stall_F/Stall_D/Flush_E, then ForwardA_E = 01 (from W).
  - With LOAD_LAT=2, expect two stall cycles and ForwardA_E = 01.
- ALU chain: `addi x3,x0,7`; `add x4,x3,x3`; `sub x5,x3,x4`.
  - Expect ForwardA_E = ForwardB_E = 10 for the add.
  - Expect ForwardA = 01 and ForwardB = 10 for the sub.
  - No stalls.
- x0 destination: `addi x0,x0,1` then `add x7,x0,x0`.
  - Expect forwards 00 and no stall.
- Taken branch in E while the D instruction is in a load-use stall.
  - Expect Flush_D = Flush_E = 1 and no stall; V_D = V_E = 0 the next cycle.
- Store in M with DmemReady_M low for 3 cycles.
  - Expect Stall_F/D/E/M high for 3 cycles and V_W = 0 for those cycles.
  - A PCSrc_E held high meanwhile produces its flush in the cycle DmemReady_M rises.
- Reset asserted mid-stream with V_* = 1111: the next cycle has all valids 0 and forwards 00.
  - With HAZARD_PERF_EN, the counters also read 0.
